// File: rtl/rom_stream_reader.sv
// Address sequencer and valid/ready stream adapter for a combinational lookup ROM.
// Walks `count` consecutive (wrapping) addresses, registers each word and accumulates accepted words.
//
// state | meaning
// IDLE  | waiting for start; rom_addr holds address after the last word read
// RUN   | fetching words from the ROM into the output register
// DRAIN | final word presented, waiting for the consumer to take it
// DONE  | one-cycle completion pulse
module rom_stream_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int SUM_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [ADDR_W-1:0]   rom_addr_d;
  logic [DATA_W-1:0]   out_data_d;
  logic                out_valid_d, out_last_d;
  logic [SUM_W-1:0]    sum_d;
  logic                fire, load;

  assign fire = out_valid & out_ready;
  assign load = (state_q == RUN) & (~out_valid | fire);
  assign busy = (state_q == RUN) | (state_q == DRAIN);
  assign done = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    rom_addr_d  = rom_addr;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    sum_d       = sum;

    if (fire) sum_d = sum + SUM_W'(out_data);

    case (state_q)
      IDLE: begin
        if (start) begin
          rom_addr_d  = base_addr;
          remaining_d = count;
          sum_d       = '0;
          out_valid_d = 1'b0;
          state_d     = (count != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // Loading on fire keeps one word per cycle with the consumer always ready.
        if (load) begin
          out_data_d  = rom_data;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == (ADDR_W+1)'(1));
          rom_addr_d  = rom_addr + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (remaining_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      rom_addr    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      sum         <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rom_addr    <= rom_addr_d;
      out_data    <= out_data_d;
      out_valid   <= out_valid_d;
      out_last    <= out_last_d;
      sum         <= sum_d;
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader: directed requests push expected beats,
// a negedge monitor pops and compares every accepted beat and checks hold stability.
module tb_rom_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  count = '0;
  logic [3:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [11:0] sum;

  typedef struct packed {logic [7:0] d; logic l;} beat_t;
  beat_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int fire_cnt = 0;
  logic busy_seen = 1'b0;
  logic bp_en = 1'b0;

  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = '0;
  logic       hold_last = 1'b0;
  logic       prev_done = 1'b0;

  always #5 clk = ~clk;

  // mem[i] = 2i+1
  assign rom_data = {3'b000, rom_addr, 1'b1};

  rom_stream_reader #(.ADDR_W(4), .DATA_W(8), .SUM_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done), .sum(sum)
  );

  // Monitor: samples mid-cycle, values are stable for the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        if (prev_done) begin
          errors++;
          $display("FAIL done_width: done high for two consecutive cycles");
        end
        done_cnt++;
      end
      prev_done = done;
      if (busy) busy_seen = 1'b1;
      if (hold_prev) begin
        checks++;
        if (!out_valid || out_data !== hold_data || out_last !== hold_last) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b data=%0d last=%0b, need valid=1 data=%0d last=%0b",
                   out_valid, out_data, out_last, hold_data, hold_last);
        end
      end
      if (out_valid && out_ready) begin
        beat_t e;
        checks++;
        fire_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra: got data=%0d last=%0b, need no beat", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_last !== e.l) begin
            errors++;
            $display("FAIL beat: got data=%0d last=%0b, need data=%0d last=%0b",
                     out_data, out_last, e.d, e.l);
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  end

  // Ready driver: always ready unless backpressure pattern 1,0,0,1,0,1 is enabled.
  initial begin
    int idx;
    logic [5:0] pat;
    idx = 0;
    pat = 6'b101001;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        out_ready = pat[idx % 6];
        idx++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int need);
    checks++;
    if (got != need) begin
      errors++;
      $display("FAIL %s: got %0d, need %0d", name, got, need);
    end
  endtask

  task automatic push_beats(input logic [3:0] b, input logic [4:0] c);
    logic [3:0] a;
    for (int i = 0; i < int'(c); i++) begin
      beat_t e;
      a = b + 4'(i);
      e.d = {3'b000, a, 1'b1};
      e.l = (i == int'(c) - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [3:0] b, input logic [4:0] c);
    push_beats(b, c);
    base_addr = b;
    count = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, need done", n);
    end
  endtask

  task automatic finish_test(input string name, input int need_sum, input int dn0, input int need_fires, input int f0);
    tick();
    tick();
    check({name, "_sum"}, int'(sum), need_sum);
    check({name, "_done_pulses"}, done_cnt - dn0, 1);
    check({name, "_beats"}, fire_cnt - f0, need_fires);
    check({name, "_queue_left"}, exp_q.size(), 0);
    check({name, "_idle"}, int'({busy, out_valid}), 0);
  endtask

  initial begin
    int n, dn0, f0;

    #2;
    check("reset_outputs", int'({rom_addr, out_data, out_valid, out_last, busy, done, sum}), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full sweep
    dn0 = done_cnt; f0 = fire_cnt;
    issue(4'd0, 5'd16);
    wait_done(n);
    check("sweep_latency", n, 17);
    finish_test("sweep", 256, dn0, 16, f0);
    check("sweep_rom_addr", int'(rom_addr), 0);

    // Wrap-around
    dn0 = done_cnt; f0 = fire_cnt;
    issue(4'd14, 5'd4);
    wait_done(n);
    finish_test("wrap", 64, dn0, 4, f0);
    check("wrap_rom_addr", int'(rom_addr), 2);

    // Backpressure
    dn0 = done_cnt; f0 = fire_cnt;
    bp_en = 1'b1;
    issue(4'd5, 5'd3);
    wait_done(n);
    bp_en = 1'b0;
    finish_test("backpressure", 39, dn0, 3, f0);

    // count = 0
    dn0 = done_cnt; f0 = fire_cnt;
    busy_seen = 1'b0;
    issue(4'd3, 5'd0);
    check("zero_done_next_cycle", int'(done), 1);
    wait_done(n);
    finish_test("zero", 0, dn0, 0, f0);
    check("zero_busy_seen", int'(busy_seen), 0);

    // Start re-pulsed while busy
    dn0 = done_cnt; f0 = fire_cnt;
    issue(4'd0, 5'd8);
    tick();
    base_addr = 4'd9; count = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    finish_test("restart_ignored", 64, dn0, 8, f0);

    // Reset mid-request
    dn0 = done_cnt; f0 = fire_cnt;
    issue(4'd0, 5'd10);
    n = 0;
    while (fire_cnt - f0 < 3 && n < 100) begin
      tick();
      n++;
    end
    check("reset_reached_beat3", fire_cnt - f0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_outputs", int'({rom_addr, out_data, out_valid, out_last, busy, done, sum}), 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("reset_no_done", done_cnt - dn0, 0);
    check("reset_idle", int'({busy, out_valid}), 0);

    dn0 = done_cnt; f0 = fire_cnt;
    issue(4'd2, 5'd2);
    wait_done(n);
    finish_test("after_reset", 12, dn0, 2, f0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
